// File: rtl/dm_responder.sv
// dm_responder: single-outstanding data-memory responder with fixed latency.
// A request is captured in IDLE, waits LATENCY cycles, executes against the
// word array on the last WAIT edge, and its result is held until handshaken.
module dm_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 3072
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3,
                         OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] addr_q, wdata_q, pc_q;
  logic [31:0] mem [DEPTH];

  logic        accept, exec;
  logic [11:0] idx;
  logic        in_range, misalign, err, is_store;
  logic [31:0] word, load, merged;
  logic [15:0] half;
  logic [7:0]  byte_l;

  assign accept = req_valid && req_ready;
  assign exec   = (state == WAIT) && (cnt == 4'd0);

  // Next-state and handshake outputs
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (accept) state_nxt = WAIT;
      end
      WAIT: if (cnt == 4'd0) state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Access decode: error check, lane extraction and store merge
  always_comb begin
    idx      = addr_q[13:2];
    in_range = (int'(idx) < DEPTH);
    word     = in_range ? mem[idx] : 32'd0;
    case (op_q)
      OP_LW, OP_SW:         misalign = |addr_q[1:0];
      OP_LH, OP_LHU, OP_SH: misalign = addr_q[0];
      default:              misalign = 1'b0;
    endcase
    err      = !in_range || misalign;
    is_store = (op_q == OP_SW) || (op_q == OP_SH) || (op_q == OP_SB);
    half     = addr_q[1] ? word[31:16] : word[15:0];
    byte_l   = word[{addr_q[1:0], 3'b000} +: 8];
    case (op_q)
      OP_LW:   load = word;
      OP_LH:   load = {{16{half[15]}}, half};
      OP_LHU:  load = {16'd0, half};
      OP_LB:   load = {{24{byte_l[7]}}, byte_l};
      OP_LBU:  load = {24'd0, byte_l};
      default: load = 32'd0;
    endcase
    merged = word;
    case (op_q)
      OP_SW:   merged = wdata_q;
      OP_SH:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      OP_SB:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      default: merged = word;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Latency counter: loaded on accept, counts down while waiting
  always_ff @(posedge clk) begin
    if (rst)                            cnt <= 4'd0;
    else if (accept)                    cnt <= 4'(LATENCY - 1);
    else if (state == WAIT && cnt != 0) cnt <= cnt - 4'd1;
  end

  // Request capture
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= req_op;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      pc_q    <= req_pc;
    end
  end

  // Memory, response registers and store trace
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (exec) begin
      resp_err   <= err;
      resp_rdata <= (err || is_store) ? 32'd0 : load;
      if (is_store && !err) begin
        mem[idx] <= merged;
        $display("%d@%h: *%h <= %h", $time, pc_q, addr_q & ~32'd3, merged);
      end
    end else if (state == RESP && resp_ready) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end
  end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to first resp_valid cycle (legal range 1..15).
REQ-002 The block SHALL have parameter DEPTH, default 3072, meaning number of 32-bit data-memory words.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 The block SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 The block SHALL have port req_op  input  3  operation: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-008 The block SHALL have port req_addr  input  32  byte address.
REQ-009 The block SHALL have port req_wdata  input  32  store data; lane taken from low bits (SB: [7:0], SH: [15:0]).
REQ-010 The block SHALL have port req_pc  input  32  PC of the issuing instruction, used only for the store trace.
REQ-011 The block SHALL have port resp_valid  output  1  response available.
REQ-012 The block SHALL have port resp_ready  input  1  initiator accepts the response.
REQ-013 The block SHALL have port resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 The block SHALL have port resp_err  output  1  request was misaligned or out of range.

Function
REQ-015 The block SHALL implement states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE with rst low.
REQ-016 In IDLE, req_valid&req_ready SHALL capture op/addr/wdata/pc, load a counter with LATENCY-1 and enter WAIT; req_valid is ignored in WAIT and RESP.
REQ-017 In WAIT, the counter SHALL decrement each cycle; at counter 0 the access executes on that edge and the state moves to RESP, so resp_valid first rises LATENCY cycles after the accept edge.
REQ-018 In RESP, resp_valid, resp_rdata and resp_err SHALL be held stable until resp_valid&resp_ready, then the state returns to IDLE and resp_valid drops on that edge.
REQ-019 The word index SHALL be addr[13:2]; an index >= DEPTH SHALL give resp_err=1, no write, rdata 0.
REQ-020 LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]=1, SHALL give resp_err=1, no write, rdata 0.
REQ-021 SW SHALL write the whole word; SH SHALL write the half selected by addr[1] (1 = bits 31:16); SB SHALL write the byte selected by addr[1:0] (3 = bits 31:24); other lanes are unchanged.
REQ-022 LH/LB SHALL sign-extend the selected lane; LHU/LBU SHALL zero-extend it; LW SHALL return the word.
REQ-023 Each successful store SHALL print "%d@%h: *%h <= %h" with $time, captured pc, word-aligned address (addr & ~3), and the full merged word after the write.
REQ-024 At most one request SHALL be outstanding, so a read after a write always sees the written data.

Reset
REQ-025 With rst high at a clock edge, the block SHALL clear all DEPTH words to 0, enter IDLE, and drive resp_valid=0, resp_rdata=0, resp_err=0, and the counter to 0.
REQ-026 Reset in WAIT or RESP SHALL discard the in-flight request: no memory write, no trace line, no response.
REQ-027 req_ready SHALL be 0 during any cycle in which rst is high.

Verification
REQ-028 Reset, then SW 0x00000010 <= 0xDEADBEEF accepted at cycle 0 -> resp_valid at cycle 2, err 0, rdata 0, trace line printed; then LW 0x10 -> rdata 0xDEADBEEF.
REQ-029 After REQ-028, SB 0x13 <= 0x00000011 -> LW 0x10 returns 0x11ADBEEF; LH 0x12 returns 0x000011AD; LB 0x10 returns 0xFFFFFFEF; LBU 0x10 returns 0x000000EF.
REQ-030 LW at 0x00000002 gives err 1, rdata 0; SH at 0x00000011 gives err 1; then LW 0x10 is unchanged and no trace line is printed.
REQ-031 Hold resp_ready=0 for 3 cycles in RESP while req_valid=1 -> resp_valid, rdata and err are stable, req_ready=0, and no second request is accepted until one cycle after the response handshake.
REQ-032 Assert rst for one cycle during WAIT of SW 0x20 <= 0x12345678 -> no response and no trace; a subsequent LW 0x20 returns 0x00000000.
REQ-033 LW at 0x00003000 (index 3072) gives err 1, rdata 0; LW at 0x00002FFC (index 3071) after reset gives err 0, rdata 0.
